mk_bsv_top: RTL and testbench
=============================

# mk_bsv_top

Top-level logic of the SPI test design: a mode-0 SPI slave, clocked from the on-chip 24 MHz oscillator, that receives 8-bit command bytes and drives the three RGB LED pins from them. Each received byte is echoed back on `spi_sdo` during the following byte transfer, so the host can verify the link as a loopback. The block sits directly under the board top, which supplies the clock and a power-on reset.

## Interface
- No parameters.
- `CLK` in 1 — system clock, 24 MHz.
- `RST_N` in 1 — reset, synchronous to `CLK`, active-low.
- `spi_sck` in 1 — SPI clock from the master, asynchronous to `CLK`, idles low (mode 0).
- `spi_ncs` in 1 — SPI chip select, active-low, asynchronous.
- `spi_sdi` in 1 — master-out data, asynchronous.
- `spi_sdo` out 1 — slave-out data, always driven (no tri-state).
- `led_red` out 1 — red LED, active-low (0 = lit).
- `led_green` out 1 — green LED, active-low.
- `led_blue` out 1 — blue LED, active-low.

## Operation
- `spi_sck`, `spi_ncs` and `spi_sdi` each pass through a 2-flop synchronizer.
- A third flop on synced `spi_sck` and `spi_ncs` provides edge detection: sck rise, sck fall, ncs fall, ncs rise.
- Internal registers:
  - `rx[7:0]` shift register.
  - `tx[7:0]` shift register.
  - `bitcnt[2:0]`.
  - `echo[7:0]`.
  - `led[2:0]`, where bit0 = red, bit1 = green, bit2 = blue.
- Frames are MSB-first, 8 bits per byte, with any number of bytes per ncs-low window.
- ncs fall: `tx <= echo`, `bitcnt <= 0`.
- sck rise while ncs low:
  - `rx <= {rx[6:0], sdi}`, `bitcnt <= bitcnt+1` (wraps 7 to 0).
  - If `bitcnt==7`, the byte is complete: `echo <= {rx[6:0], sdi}` and `led <= {rx[1:0], sdi}` (the received byte's bits [2:0]).
- sck fall while ncs low:
  - If `bitcnt==0` (byte boundary): `tx <= echo`.
  - Otherwise: `tx <= {tx[6:0], 1'b0}`.
- `spi_sdo = tx[7]` while synced ncs is low; 0 while ncs is high.
- ncs rise: `bitcnt <= 0`, and any partial byte is discarded (`led` and `echo` unchanged).
- sck edges while ncs is high are ignored.
- LED outputs: `led_x = ~led[x]`, subject to Configuration.
- Reply stream:
  - Byte n of a frame returns byte n-1 of the same frame.
  - The first byte of a frame returns the last complete byte of the previous frame, or 0x00 after reset.

## Timing
- Synchronous reset (`RST_N`=0 at a `CLK` edge) clears all registers and synchronizers to 0. Outputs in reset: `spi_sdo`=0, and all LED pins = 1 (off).
- Latency from a pin edge to the internal edge pulse is 3 `CLK` cycles.
- `led` and `echo` update 3–4 `CLK` after the 8th sck rise; LED pins change 1 `CLK` after `led`.
- `spi_sdo` is valid at most 4 `CLK` after ncs fall or sck fall.
- Master requirements:
  - ≥ 6 `CLK` (250 ns) from ncs fall to the first sck rise.
  - sck high and low phases each ≥ 6 `CLK` (sck ≤ 2 MHz).
  - ≥ 6 `CLK` from the last sck fall to ncs rise.
- Simultaneous edge events in one `CLK` cycle: ncs rise takes priority over any sck edge.
- Reset asserted mid-byte aborts the byte. After reset releases, the first ncs fall starts a clean frame; sck edges seen before that are ignored because synced ncs is not low.

## Configuration
- `HEARTBEAT_EN`:
  - Defined: a 24-bit free-running counter (reset 0, wraps) drives `led_red = ~cnt[23]`, toggling every 2^23 `CLK` (≈0.35 s). `led[0]` is still stored and echoed but does not reach the pin.
  - Undefined: no counter, and `led_red = ~led[0]`.

## Test plan
- Reset: hold `RST_N`=0 for 15 cycles, then release → `spi_sdo`=0, `led_red/green/blue`=1,1,1, and stay so with SPI idle (ncs high).
- Single byte: one frame sending 0x05 → `spi_sdo` returns 0x00. After the frame, `led_red`=0, `led_green`=1, `led_blue`=0.
- Multi-byte frame: send 0x3C, 0xA5, 0x07 in one ncs-low window → replies 0x05, 0x3C, 0xA5. LEDs end as all lit (0,0,0); `echo` = 0x07.
- Next frame: send 0x00 → reply 0x07, and all LEDs go off.
- Aborted byte: raise ncs after 5 sck pulses carrying 1s → LEDs and echo unchanged. The next full frame sending 0x02 replies with the previous echo, and only `led_green`=0.
- Ignore and reset: sck toggling with ncs high changes nothing. Reset pulsed mid-frame → LEDs off, `spi_sdo`=0, next frame replies 0x00. With `HEARTBEAT_EN` defined, `led_red` toggles at cycles 2^23 and 2^24 after reset.

Source files
------------

// File: rtl/mk_bsv_top.sv
// mk_bsv_top: SPI test design top. Mode-0 SPI slave that receives command bytes,
// drives the RGB LEDs from bits [2:0] of each completed byte, and loops every
// byte back on spi_sdo during the following byte transfer.
//
// Ports:
//   CLK        in  24 MHz system clock
//   RST_N      in  synchronous active-low reset
//   spi_sck    in  SPI clock (async, mode 0, idles low)
//   spi_ncs    in  SPI chip select (async, active-low)
//   spi_sdi    in  SPI master-out data (async)
//   spi_sdo    out SPI slave-out data, 0 while deselected
//   led_red    out red LED, active-low
//   led_green  out green LED, active-low
//   led_blue   out blue LED, active-low
//
// Build option: define HEARTBEAT_EN to drive led_red from bit 23 of a
// free-running counter instead of the received command bit.
module mk_bsv_top (
  input  logic CLK,
  input  logic RST_N,
  input  logic spi_sck,
  input  logic spi_ncs,
  input  logic spi_sdi,
  output logic spi_sdo,
  output logic led_red,
  output logic led_green,
  output logic led_blue
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned RX_W   = BYTE_W - 1;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned LED_W  = 3;
  localparam int unsigned SYNC_W = 2;

  // Input synchronizers plus one delay stage on sck/ncs for edge detection
  logic [SYNC_W-1:0] sck_sync, ncs_sync, sdi_sync;
  logic              sck_d, ncs_d;

  // rx keeps the seven bits already shifted in; the eighth completes the byte
  // straight into echo, so a full 8-bit rx would carry a dead top bit.
  logic [RX_W-1:0]   rx, rx_n;
  logic [BYTE_W-1:0] tx, tx_n;
  logic [CNT_W-1:0]  bitcnt, bitcnt_n;
  logic [BYTE_W-1:0] echo, echo_n;
  logic [LED_W-1:0]  led, led_n;

  logic sck_s, ncs_s, sdi_s;
  logic sck_rise, sck_fall, ncs_fall, ncs_rise;
  logic red_pin_n;

  assign sck_s = sck_sync[SYNC_W-1];
  assign ncs_s = ncs_sync[SYNC_W-1];
  assign sdi_s = sdi_sync[SYNC_W-1];

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign ncs_fall = ~ncs_s & ncs_d;
  assign ncs_rise = ncs_s & ~ncs_d;

  // Synchronizer and edge-detect flops
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sck_sync <= '0;
      ncs_sync <= '0;
      sdi_sync <= '0;
      sck_d    <= 1'b0;
      ncs_d    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_W-2:0], spi_sck};
      ncs_sync <= {ncs_sync[SYNC_W-2:0], spi_ncs};
      sdi_sync <= {sdi_sync[SYNC_W-2:0], spi_sdi};
      sck_d    <= sck_s;
      ncs_d    <= ncs_s;
    end
  end

  // Shift/byte next-state; ncs rise outranks any coincident sck edge
  always_comb begin
    rx_n     = rx;
    tx_n     = tx;
    bitcnt_n = bitcnt;
    echo_n   = echo;
    led_n    = led;
    if (ncs_rise) begin
      bitcnt_n = '0;
    end else if (ncs_fall) begin
      tx_n     = echo;
      bitcnt_n = '0;
    end else if (!ncs_s) begin
      if (sck_rise) begin
        rx_n     = {rx[RX_W-2:0], sdi_s};
        bitcnt_n = CNT_W'(bitcnt + CNT_W'(1));
        if (bitcnt == CNT_W'(7)) begin
          echo_n = {rx, sdi_s};
          led_n  = {rx[1:0], sdi_s};
        end
      end else if (sck_fall) begin
        // bitcnt wrapped to 0 means the next bit is the MSB of a new byte
        if (bitcnt == '0) tx_n = echo;
        else              tx_n = {tx[BYTE_W-2:0], 1'b0};
      end
    end
  end

  // SPI datapath state
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx     <= '0;
      tx     <= '0;
      bitcnt <= '0;
      echo   <= '0;
      led    <= '0;
    end else begin
      rx     <= rx_n;
      tx     <= tx_n;
      bitcnt <= bitcnt_n;
      echo   <= echo_n;
      led    <= led_n;
    end
  end

`ifdef HEARTBEAT_EN
  localparam int unsigned HB_W = 24;
  logic [HB_W-1:0] hb_cnt;

  // Free-running heartbeat counter
  always_ff @(posedge CLK) begin
    if (!RST_N) hb_cnt <= '0;
    else        hb_cnt <= HB_W'(hb_cnt + HB_W'(1));
  end

  assign red_pin_n = ~hb_cnt[HB_W-1];
`else
  assign red_pin_n = ~led[0];
`endif

  // Registered active-low LED pins
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      led_red   <= 1'b1;
      led_green <= 1'b1;
      led_blue  <= 1'b1;
    end else begin
      led_red   <= red_pin_n;
      led_green <= ~led[1];
      led_blue  <= ~led[2];
    end
  end

  // ncs_d aligns the select gate with the tx load that follows an ncs fall
  assign spi_sdo = ~ncs_d & tx[BYTE_W-1];

endmodule

// File: tb/tb_mk_bsv_top.sv
// tb_mk_bsv_top: self-checking bench for mk_bsv_top. A bench-side echo/LED
// model pushes the expected reply of each byte into a scoreboard queue when the
// byte is sent; the captured reply is popped and compared at the end of it.
module tb_mk_bsv_top;

  localparam int unsigned HALF = 8;   // CLK cycles per sck phase

  logic clk = 1'b0;
  logic rst_n;
  logic spi_sck, spi_ncs, spi_sdi;
  logic spi_sdo, led_red, led_green, led_blue;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sb[$];
  logic [7:0] exp_echo;
  logic [2:0] exp_led;

  mk_bsv_top dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .spi_sck   (spi_sck),
    .spi_ncs   (spi_ncs),
    .spi_sdi   (spi_sdi),
    .spi_sdo   (spi_sdo),
    .led_red   (led_red),
    .led_green (led_green),
    .led_blue  (led_blue)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_leds(input string tag);
    logic [2:0] pins_exp;
    pins_exp = ~exp_led;
    check(tag, 32'({led_blue, led_green, led_red}), 32'(pins_exp));
  endtask

  // One mode-0 byte: master samples sdo just before each sck rise
  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      spi_sdi = b[i];
      wait_clk(HALF);
      r[i] = spi_sdo;
      spi_sck = 1'b1;
      wait_clk(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic frame_start();
    spi_ncs = 1'b0;
    wait_clk(10);
  endtask

  task automatic frame_end();
    wait_clk(HALF);
    spi_ncs = 1'b1;
    wait_clk(10);
    check("sdo_idle", 32'(spi_sdo), 32'd0);
  endtask

  task automatic xfer(input logic [7:0] b);
    logic [7:0] r, e;
    sb.push_back(exp_echo);
    spi_byte(b, r);
    e = sb.pop_front();
    check("reply", 32'(r), 32'(e));
    exp_echo = b;
    exp_led  = b[2:0];
  endtask

  task automatic partial(input int nbits, input logic v);
    for (int i = 0; i < nbits; i++) begin
      spi_sdi = v;
      wait_clk(HALF);
      spi_sck = 1'b1;
      wait_clk(HALF);
      spi_sck = 1'b0;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    spi_sck  = 1'b0;
    spi_ncs  = 1'b1;
    spi_sdi  = 1'b0;
    exp_echo = 8'h00;
    exp_led  = 3'b000;

    // Reset
    wait_clk(15);
    check("rst_sdo", 32'(spi_sdo), 32'd0);
    check_leds("rst_leds");
    rst_n = 1'b1;
    wait_clk(20);
    check("idle_sdo", 32'(spi_sdo), 32'd0);
    check_leds("idle_leds");

    // Single byte
    frame_start();
    xfer(8'h05);
    frame_end();
    check_leds("leds_05");

    // Multi-byte frame
    frame_start();
    xfer(8'h3C);
    xfer(8'hA5);
    xfer(8'h07);
    frame_end();
    check_leds("leds_07");

    // Next frame, all off
    frame_start();
    xfer(8'h00);
    frame_end();
    check_leds("leds_00");

    // Aborted byte leaves model state untouched
    frame_start();
    partial(5, 1'b1);
    frame_end();
    check_leds("leds_abort");
    frame_start();
    xfer(8'h02);
    frame_end();
    check_leds("leds_02");

    // sck activity while deselected is ignored
    spi_sdi = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_clk(HALF);
      spi_sck = 1'b1;
      wait_clk(HALF);
      spi_sck = 1'b0;
    end
    wait_clk(10);
    check("ign_sdo", 32'(spi_sdo), 32'd0);
    check_leds("leds_ign");
    frame_start();
    xfer(8'h01);
    frame_end();
    check_leds("leds_01");

    // Reset pulsed mid-frame
    frame_start();
    partial(3, 1'b1);
    rst_n = 1'b0;
    wait_clk(5);
    exp_echo = 8'h00;
    exp_led  = 3'b000;
    check("midrst_sdo", 32'(spi_sdo), 32'd0);
    check_leds("midrst_leds");
    spi_ncs = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(10);
    check("postrst_sdo", 32'(spi_sdo), 32'd0);
    check_leds("postrst_leds");
    frame_start();
    xfer(8'h06);
    xfer(8'hC3);
    frame_end();
    check_leds("leds_c3");

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
